serial_subtractor: RTL
======================

Name: serial_subtractor

Overview:
Bit-serial WIDTH-bit subtractor computing d = a - b - bin with borrow-out. It is the inverse operation of the team's combinational ripple adder. It processes one bit per clock, LSB first, through a start/busy/done handshake. It is intended as a small-area arithmetic unit and as a sequential counterpart in the module-instantiation exercises.

Parameters:
WIDTH, 4, operand and result width in bits (legal range 2..16)

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only when busy=0
a  input  WIDTH  minuend; captured on the accepting edge
b  input  WIDTH  subtrahend; captured on the accepting edge
bin  input  1  borrow-in; captured on the accepting edge
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse when d/bout become valid
d  output  WIDTH  difference, registered, held until the next completion
bout  output  1  borrow-out, registered, held until the next completion

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: busy=0, done=0, d=0, bout=0. FSM in IDLE. Internal shift registers, bit counter and borrow flop cleared.
- FSM states:
  - IDLE: busy=0. On start=1, go to SHIFT. Load a_sh<=a, b_sh<=b, r_sh<=0, borrow<=bin, cnt<=0, busy<=1.
  - SHIFT: busy=1, one bit per cycle.
    - diff = a_sh[0] ^ b_sh[0] ^ borrow
    - borrow_next = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & borrow)
    - a_sh and b_sh shift right. diff shifts into r_sh MSB. cnt increments.
    - On the edge where cnt = WIDTH-1, go straight to IDLE: d<={diff, r_sh[WIDTH-1:1]}, bout<=borrow_next, done<=1, busy<=0.
- No separate DONE state. done is registered and deasserts on the following edge unless another completion occurs.
- Latency:
  - start accepted at edge T0.
  - busy=1 from after T0 until edge T0+WIDTH.
  - done=1 and d/bout valid during the cycle after edge T0+WIDTH.
  - Throughput: one result per WIDTH+1 cycles with back-to-back starts.
- Arithmetic: {bout,d} equals the (WIDTH+1)-bit two's-complement value of a - b - bin.
  - bout=1 iff a < b + bin (unsigned).
  - d = (a - b - bin) mod 2^WIDTH.
- start while busy=1: ignored, no queuing. Operands of the in-flight operation are unaffected by changes on a, b or bin.
- start in the cycle done=1: accepted, since busy=0 in that cycle. The new operation begins. d/bout keep the just-completed value until the new completion.
- d/bout change only at a completion edge or at reset. They never show partial results.
- Reset mid-operation: immediate abort to reset values. No done pulse is generated for the aborted operation.
- Operands sampled with X while start=0: no effect.

Test Plan:
1. Reset, then a=5, b=3, bin=0, start for 1 cycle -> busy high 4 cycles; done pulses 1 cycle at edge T0+4 with d=4'b0010, bout=0.
2. a=3, b=5, bin=0 -> d=4'b1110, bout=1. Then a=0, b=0, bin=1 -> d=4'b1111, bout=1. Then a=15, b=15, bin=0 -> d=0, bout=0.
3. Exhaustive loop over all 512 {a,b,bin} combinations with start re-asserted on each done cycle -> every result matches {bout,d} == (a - b - bin) mod 32; exactly 512 done pulses; each result arrives 5 cycles after the previous one.
4. Start a=9, b=2, bin=0; at T0+2 pulse start with a=1, b=7 and change a/b -> second start ignored; result d=7, bout=0; only one done pulse.
5. Start a=12, b=4; assert rst_n=0 at T0+2 for 1 cycle -> busy, done, d and bout go to 0 immediately; no done pulse follows; a fresh start of 12-4 afterwards returns d=8, bout=0.
6. Hold start=1 continuously with a=6, b=1, bin=1 -> done every 5 cycles; d=4 and bout=0 on each done; d is stable between pulses.

Source files
------------

// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor.
// Handshake: start is taken on a rising edge only while busy=0; done pulses for one cycle when d/bout update.
interface serial_subtractor_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] d;
  logic             bout;

  modport master (
    output start, a, b, bin,
    input  busy, done, d, bout
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, d, bout
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin, LSB first, one bit per clock; {bout,d} is the (WIDTH+1)-bit difference.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  serial_subtractor_if.slave bus,
  output logic              fsm_state
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] r_sh;
  logic [CW-1:0]    cnt;
  logic             borrow;
  logic             diff;
  logic             borrow_next;
  logic             load;
  logic             finish;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = SHIFT;
      SHIFT:   if (cnt == LAST) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.busy    = (state == SHIFT);
    load        = (state == IDLE) && bus.start;
    finish      = (state == SHIFT) && (cnt == LAST);
    diff        = a_sh[0] ^ b_sh[0] ^ borrow;
    borrow_next = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & borrow);
  end

  assign fsm_state = state;

  // Results land only on the final shift edge, so d/bout never expose partial sums.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh     <= '0;
      b_sh     <= '0;
      r_sh     <= '0;
      cnt      <= '0;
      borrow   <= 1'b0;
      bus.done <= 1'b0;
      bus.d    <= '0;
      bus.bout <= 1'b0;
    end else begin
      bus.done <= finish;
      if (load) begin
        a_sh   <= bus.a;
        b_sh   <= bus.b;
        r_sh   <= '0;
        borrow <= bus.bin;
        cnt    <= '0;
      end else if (state == SHIFT) begin
        a_sh   <= a_sh >> 1;
        b_sh   <= b_sh >> 1;
        r_sh   <= {diff, r_sh[WIDTH-1:1]};
        borrow <= borrow_next;
        cnt    <= cnt + CW'(1);
      end
      if (finish) begin
        bus.d    <= {diff, r_sh[WIDTH-1:1]};
        bus.bout <= borrow_next;
      end
    end
  end
endmodule
